// File: rtl/mux8_rr_sched.sv
`timescale 1ns/1ps
// mux8_rr_sched: round-robin scheduler sharing one 8-to-1 mux among eight requesters.
// Drives the mux address (c,b,a) and active-low strobe g with break-before-make
// sequencing, issues a one-hot grant, and limits hold time to MAXHOLD cycles.
// Ports:
//   clk    - system clock, rising edge
//   clr_n  - asynchronous active-low reset
//   req    - request lines, req[i] asks for mux input i
//   done   - current owner releases the mux (sampled in GRANT only)
//   c,b,a  - mux select bits 2..0 (registered)
//   g      - mux strobe, active-low (registered), low only in GRANT
//   gnt    - one-hot grant (registered)
//   busy   - high in SETUP, GRANT and RELEASE (registered)
//   tout   - one-cycle pulse when the hold limit alone revokes a grant (registered)
module mux8_rr_sched #(
  parameter int unsigned MAXHOLD = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       c,
  output logic       b,
  output logic       a,
  output logic       g,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       tout
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned PW   = 3;
  localparam int unsigned CW   = 8;
  localparam bit          HOLD_EN   = (MAXHOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAXHOLD == 0) ? 0 : (MAXHOLD - 1));

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, RELEASE} state_t;

  state_t        state, state_d;
  logic [PW-1:0] ptr, ptr_d;
  logic [PW-1:0] owner, owner_d;
  logic [CW-1:0] cnt, cnt_d;

  logic [PW-1:0] cba_d;
  logic          g_d;
  logic [7:0]    gnt_d;
  logic          busy_d;
  logic          tout_d;

  logic [PW-1:0] win;
  logic          win_vld;
  logic [PW-1:0] idx;
  logic          lim_hit;
  logic          rel_hit;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + PW'(i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Exit causes while in GRANT; the limit is only armed when MAXHOLD is non-zero.
  always_comb begin
    lim_hit = HOLD_EN && (cnt == HOLD_LAST);
    rel_hit = done || !req[owner];
  end

  // State register, also capturing the next output values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      {c, b, a} <= 3'b000;
      g         <= 1'b1;
      gnt       <= '0;
      busy      <= 1'b0;
      tout      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      cnt       <= cnt_d;
      {c, b, a} <= cba_d;
      g         <= g_d;
      gnt       <= gnt_d;
      busy      <= busy_d;
      tout      <= tout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          owner_d = win;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!req[owner]) begin
          state_d = RELEASE;
        end else begin
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_hit || lim_hit) begin
          state_d = RELEASE;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_d = cnt + CW'(1);
        end
      end
      RELEASE: begin
        ptr_d   = owner + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next output values; address only moves when leaving IDLE, while g is high.
  always_comb begin
    cba_d  = {c, b, a};
    g_d    = 1'b1;
    gnt_d  = '0;
    busy_d = 1'b0;
    tout_d = 1'b0;
    if (state == IDLE && win_vld) begin
      cba_d = win;
    end
    if (state_d == GRANT) begin
      g_d = 1'b0;
    end
    if (state_d == SETUP || state_d == GRANT) begin
      gnt_d = 8'(1) << owner_d;
    end
    busy_d = (state_d != IDLE);
    tout_d = (state == GRANT) && lim_hit && !rel_hit;
  end

endmodule

// File: tb/tb_mux8_rr_sched.sv
`timescale 1ns/1ps
// Bench for mux8_rr_sched: a phase-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mux8_rr_sched;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] req;
  logic       done;
  logic       c, b, a, g, busy, tout;
  logic [7:0] gnt;

  int total = 0;
  int bad   = 0;

  mux8_rr_sched #(.MAXHOLD(MH)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .done(done),
    .c(c), .b(b), .a(a), .g(g), .gnt(gnt), .busy(busy), .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 address setup, 2 strobe low, 3 release.
  int m_phase, m_ptr, m_owner, m_held, m_cba;
  bit m_tout;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_held = 0; m_cba = 0; m_tout = 0;
    end else begin
      bit lim, oth;
      m_tout = 0;
      case (m_phase)
        0: if (req != 8'h00) begin
             for (int i = 7; i >= 0; i--)
               if (req[(m_ptr + i) % 8]) m_owner = (m_ptr + i) % 8;
             m_cba   = m_owner;
             m_phase = 1;
           end
        1: if (!req[m_owner]) m_phase = 3;
           else begin m_held = 0; m_phase = 2; end
        2: begin
             lim = (MH != 0) && (m_held + 1 >= MH);
             oth = done || !req[m_owner];
             if (lim || oth) begin
               m_phase = 3;
               m_tout  = lim && !oth;
             end else m_held++;
           end
        default: begin
             m_ptr   = (m_owner + 1) % 8;
             m_phase = 0;
           end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (clr_n === 1'b1) begin
      chk("model_cba",  {5'b0, c, b, a}, 8'(m_cba));
      chk("model_g",    {7'b0, g},       (m_phase == 2) ? 8'd0 : 8'd1);
      chk("model_gnt",  gnt, (m_phase == 1 || m_phase == 2) ? 8'(1 << m_owner) : 8'h00);
      chk("model_busy", {7'b0, busy},    (m_phase != 0) ? 8'd1 : 8'd0);
      chk("model_tout", {7'b0, tout},    {7'b0, m_tout});
    end
  end

  // One full grant starting from an IDLE negedge; ends at the following IDLE negedge.
  task automatic do_grant(input logic [7:0] r, input int hold, input logic [7:0] r_after,
                          output int own, output logic [7:0] sg, output int lowc);
    req  = r;
    lowc = 0;
    @(negedge clk);
    own = int'({c, b, a});
    sg  = gnt;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (g == 1'b0) lowc++;
      if (k == hold) done = 1'b1;
    end
    @(negedge clk);
    done = 1'b0;
    req  = r_after;
    @(negedge clk);
  endtask

  int         own, lowc, n;
  logic [7:0] sg;
  int         rr_exp[4] = '{0, 7, 0, 7};

  initial begin
    clr_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #12;
    chk("reset_g", {7'b0, g}, 8'd1);
    chk("reset_gnt", gnt, 8'h00);
    @(negedge clk);
    clr_n = 1'b1;

    // Idle with no requests.
    repeat (10) @(negedge clk);
    chk("idle_g", {7'b0, g}, 8'd1);
    chk("idle_gnt", gnt, 8'h00);
    chk("idle_cba", {5'b0, c, b, a}, 8'd0);
    chk("idle_busy", {7'b0, busy}, 8'd0);

    // Round-robin between requesters 0 and 7, done on first GRANT cycle.
    for (int j = 0; j < 4; j++) begin
      do_grant(8'h81, 1, 8'h81, own, sg, lowc);
      chk("rr_owner", 8'(own), 8'(rr_exp[j]));
      chk("rr_low_cycles", 8'(lowc), 8'd1);
    end

    // Single requester 2, done on third GRANT cycle.
    do_grant(8'h04, 3, 8'h00, own, sg, lowc);
    chk("single_cba", 8'(own), 8'd2);
    chk("single_gnt", sg, 8'h04);
    chk("single_low_cycles", 8'(lowc), 8'd3);
    chk("single_tout", {7'b0, tout}, 8'd0);
    // Pointer now 3: requesters 0 and 3 pending, 3 must win.
    do_grant(8'h09, 1, 8'h00, own, sg, lowc);
    chk("ptr3_owner", 8'(own), 8'd3);

    // Hold-limit timeout on requester 5.
    req = 8'h20;
    @(negedge clk);
    chk("tout_setup_cba", {5'b0, c, b, a}, 8'd5);
    lowc = 0;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
      if (g == 1'b0) lowc++;
    end while (g == 1'b0 && n < 20);
    chk("tout_wait_bound_g", {7'b0, g}, 8'd1);
    chk("tout_low_cycles", 8'(lowc), 8'd4);
    chk("tout_pulse", {7'b0, tout}, 8'd1);
    chk("tout_release_gnt", gnt, 8'h00);
    @(negedge clk);
    chk("tout_idle_tout", {7'b0, tout}, 8'd0);
    chk("tout_idle_busy", {7'b0, busy}, 8'd0);
    @(negedge clk);
    chk("tout_regrant_cba", {5'b0, c, b, a}, 8'd5);
    chk("tout_regrant_gnt", gnt, 8'h20);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 8'h00;
    @(negedge clk);

    // Request 4 dropped during SETUP.
    req = 8'h10;
    @(negedge clk);
    chk("drop_setup_cba", {5'b0, c, b, a}, 8'd4);
    req = 8'h00;
    @(negedge clk);
    chk("drop_release_g", {7'b0, g}, 8'd1);
    chk("drop_release_tout", {7'b0, tout}, 8'd0);
    chk("drop_release_busy", {7'b0, busy}, 8'd1);
    @(negedge clk);
    // Pointer now 5: requesters 4 and 5 pending, 5 must win.
    do_grant(8'h30, 1, 8'h00, own, sg, lowc);
    chk("ptr5_owner", 8'(own), 8'd5);
    chk("drop_never_low_then_grant", 8'(lowc), 8'd1);

    // Asynchronous reset in the middle of owner 6's grant.
    req = 8'h40;
    @(negedge clk);
    chk("rst_setup_cba", {5'b0, c, b, a}, 8'd6);
    @(negedge clk);
    chk("rst_grant_g", {7'b0, g}, 8'd0);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_g", {7'b0, g}, 8'd1);
    chk("async_gnt", gnt, 8'h00);
    chk("async_cba", {5'b0, c, b, a}, 8'd0);
    chk("async_busy", {7'b0, busy}, 8'd0);
    @(negedge clk);
    req   = 8'h81;
    clr_n = 1'b1;
    @(negedge clk);
    chk("after_rst_owner", {5'b0, c, b, a}, 8'd0);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 8'h00;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
